// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller: EMPTY/ACTIVE/FULL FSM, zero-latency read handshake.
// Define FIFO_PTR_ERR_EN to enable the sticky overflow/underflow flags (ovf_err, udf_err).
module fifo_ptr_ctrl #(
  parameter int OSTD_NUM        = 8,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1
) (
  input  logic                clk_in,
  input  logic                areset_b,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic                fifo_wenable,
  output logic                fifo_renable,
  output logic [OSTD_NUM-1:0] write_ptr,
  output logic [OSTD_NUM-1:0] read_ptr,
  output logic [PTR_SIZE:0]   fifo_count,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                below_thresh,
  input  logic                err_clr,
  output logic                ovf_err,
  output logic                udf_err
);

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

  localparam logic [PTR_SIZE:0]   COUNT_ONE    = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE:0]   COUNT_ALMOST = (PTR_SIZE+1)'(OSTD_NUM - 1);
  localparam logic [PTR_SIZE-1:0] PTR_LAST     = PTR_SIZE'(OSTD_NUM - 1);
  localparam logic [31:0]         THRESH_W     = 32'(THRESHOLD_VALUE);

  state_t              state, state_nxt;
  logic [PTR_SIZE-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_SIZE-1:0] rd_ptr, rd_ptr_nxt;
  logic [PTR_SIZE:0]   count, count_nxt;
  logic                push, pop;

  assign fifo_empty   = (state == EMPTY);
  assign fifo_full    = (state == FULL);
  assign wr_ready     = !fifo_full;
  assign rd_valid     = !fifo_empty;
  assign fifo_renable = !fifo_empty;

  // Handshakes are gated by registered state only, so a full FIFO never takes a
  // push and an empty one never takes a pop, whatever the other side does.
  assign push         = wr_valid && wr_ready;
  assign pop          = rd_ready && rd_valid;
  assign fifo_wenable = push;

  assign write_ptr    = OSTD_NUM'(wr_ptr);
  assign read_ptr     = OSTD_NUM'(rd_ptr);
  assign fifo_count   = count;
  assign below_thresh = (32'(count) < THRESH_W);

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;

    if (push) wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_SIZE'(1);
    if (pop)  rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_SIZE'(1);

    if (push && !pop)      count_nxt = count + COUNT_ONE;
    else if (pop && !push) count_nxt = count - COUNT_ONE;

    case (state)
      EMPTY:   if (push) state_nxt = ACTIVE;
      ACTIVE: begin
        if (push && !pop && count == COUNT_ALMOST) state_nxt = FULL;
        else if (pop && !push && count == COUNT_ONE) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ACTIVE;
      default: state_nxt = EMPTY;
    endcase
  end

`ifdef FIFO_PTR_ERR_EN
  // A new error event wins over a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_valid && fifo_full) ovf_err <= 1'b1;
      else if (err_clr)          ovf_err <= 1'b0;
      if (rd_ready && fifo_empty) udf_err <= 1'b1;
      else if (err_clr)           udf_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
  assign udf_err        = 1'b0;
`endif

endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter OSTD_NUM, default 8, FIFO depth (entries), a power of two, at least 2.
REQ-002 The block SHALL have parameter THRESHOLD_VALUE, default OSTD_NUM/2, low-watermark level.
REQ-003 The block SHALL have parameter PTR_SIZE, default (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1, internal binary pointer width.
REQ-004 The block SHALL use reset areset_b, asynchronous, active-low, and clock clk_in.
REQ-005 The block SHALL have these ports:
- clk_in  input  1  clock
- areset_b  input  1  async reset, active low
- wr_valid  input  1  producer push request
- wr_ready  output  1  push can be accepted
- rd_ready  input  1  consumer pop request
- rd_valid  output  1  read data valid on memory data_out
- fifo_wenable  output  1  memory write strobe
- fifo_renable  output  1  memory read enable
- write_ptr  output  OSTD_NUM  memory write index, binary, zero-extended
- read_ptr  output  OSTD_NUM  memory read index, binary, zero-extended
- fifo_count  output  PTR_SIZE+1  occupancy, 0..OSTD_NUM
- fifo_full  output  1  count == OSTD_NUM
- fifo_empty  output  1  count == 0
- below_thresh  output  1  count < THRESHOLD_VALUE
- err_clr  input  1  clear sticky error flags
- ovf_err  output  1  sticky overflow flag
- udf_err  output  1  sticky underflow flag

Function
REQ-006 The block SHALL hold a 3-state FSM: EMPTY (count 0), ACTIVE (0 < count < OSTD_NUM), FULL (count OSTD_NUM); fifo_empty = (state == EMPTY) and fifo_full = (state == FULL).
REQ-007 The block SHALL drive wr_ready = !fifo_full and rd_valid = fifo_renable = !fifo_empty, combinationally from registered state.
REQ-008 The block SHALL accept a push when wr_valid && wr_ready, driving fifo_wenable high in that same cycle with write_ptr at the current write pointer.
REQ-009 The block SHALL accept a pop when rd_ready && rd_valid; read data is valid on data_out in the same cycle from read_ptr, giving zero-cycle read latency.
REQ-010 The block SHALL increment the write pointer on an accepted push and the read pointer on an accepted pop, at the next clk_in rising edge, wrapping from OSTD_NUM-1 to 0.
REQ-011 The block SHALL update fifo_count by +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-012 The FSM SHALL make these transitions: EMPTY->ACTIVE on push; ACTIVE->FULL on push only when count == OSTD_NUM-1; ACTIVE->EMPTY on pop only when count == 1; FULL->ACTIVE on pop; otherwise it holds.
REQ-013 When full, a push SHALL NOT be accepted even if a pop occurs in the same cycle; the pop completes and the state becomes ACTIVE.
REQ-014 When empty, a pop SHALL NOT be accepted even if a push occurs in the same cycle; no pass-through, and the written data is first readable next cycle.
REQ-015 In ACTIVE, simultaneous push and pop SHALL both be accepted, both pointers SHALL advance, and count and state SHALL hold.
REQ-016 The block SHALL drive below_thresh = (fifo_count < THRESHOLD_VALUE) combinationally.

Reset
REQ-017 On areset_b low, asynchronously: pointers 0, count 0, state EMPTY, ovf_err/udf_err 0; outputs therefore wr_ready 1, rd_valid 0, fifo_empty 1, fifo_full 0, fifo_wenable 0, below_thresh 1 when THRESHOLD_VALUE > 0.
REQ-018 Reset asserted mid-operation SHALL discard all occupancy; entries in the memory are not read again after reset release.

Configuration
REQ-019 With macro FIFO_PTR_ERR_EN defined, ovf_err SHALL set on wr_valid && fifo_full, and udf_err SHALL set on rd_ready && fifo_empty; both hold until err_clr, and set has priority over err_clr in the same cycle.
REQ-020 Without FIFO_PTR_ERR_EN, ovf_err and udf_err SHALL be constant 0, err_clr SHALL be ignored, and all other behaviour SHALL be identical.

Verification (OSTD_NUM=8, THRESHOLD_VALUE=4)
REQ-021 Reset, then 8 consecutive pushes -> write_ptr 0..7, count 8, fifo_full 1, wr_ready 0, below_thresh 0 after the 4th push.
REQ-022 From full, 8 consecutive pops -> read_ptr 0..7, count 0, fifo_empty 1; a 9th push then targets write_ptr 0, confirming wrap.
REQ-023 Count 3 with push+pop every cycle for 10 cycles -> count stays 3, both pointers advance by 10 mod 8 = 2.
REQ-024 Full, with wr_valid=1 and rd_ready=1 -> fifo_wenable 0, pop accepted, count 7; empty with both high -> only push accepted, count 1, rd_valid 1 next cycle.
REQ-025 With FIFO_PTR_ERR_EN: push while full -> ovf_err 1 and sticky; err_clr pulse -> 0; pop while empty -> udf_err 1. Without the macro -> flags stay 0.
REQ-026 areset_b pulsed low at count 5 -> all outputs match REQ-017 values immediately, without waiting for clk_in.
